// File: rtl/xc_fsh_pkg.sv
// rtl/xc_fsh_pkg.sv - shared types and helpers for the multi-cycle funnel shifter
//
// Purpose: op encoding, controller state encoding and the effective shift
// amount helper used by xc_funnel_shift_mc.
// Ports: none (package).
package xc_fsh_pkg;

  // Widest shift-amount field across the supported XLENs (64 -> 7 bits).
  localparam int FSH_AMT_W = 7;

  typedef enum logic [1:0] {
    OP_FSR = 2'b00,
    OP_FSL = 2'b01,
    OP_ROR = 2'b10,
    OP_ROL = 2'b11
  } fsh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } fsh_state_e;

  // Plain rotates only look at shamt mod XLEN; funnel shifts use all bits.
  function automatic logic [FSH_AMT_W-1:0] fsh_eff_amt(
    input fsh_op_e               op,
    input logic [FSH_AMT_W-1:0]  shamt,
    input int                    xlen
  );
    if (op == OP_ROR || op == OP_ROL) begin
      return shamt & FSH_AMT_W'(xlen - 1);
    end
    return shamt;
  endfunction

  // FSL and ROL rotate the working register left, FSR and ROR right.
  function automatic logic fsh_is_left(input fsh_op_e op);
    return (op == OP_FSL) || (op == OP_ROL);
  endfunction

  function automatic logic fsh_is_rot(input fsh_op_e op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/xc_fsh_step.sv
// rtl/xc_fsh_step.sv - combinational rotator of an N-bit word by 0..STEP bits
//
// Purpose: one per-cycle rotation step of the working register, built as a
// log2(STEP)+1 stage barrel.
// Ports:
//   i_data  [N-1:0]   word to rotate
//   i_amt   [AW-1:0]  rotate amount, 0..STEP
//   i_left  1         1 = rotate left, 0 = rotate right
//   o_data  [N-1:0]   rotated word
module xc_fsh_step #(
  parameter int N    = 64,
  parameter int STEP = 8,
  parameter int AW   = $clog2(STEP) + 1
) (
  input  logic [N-1:0]  i_data,
  input  logic [AW-1:0] i_amt,
  input  logic          i_left,
  output logic [N-1:0]  o_data
);

  logic [N-1:0] w_stage [AW+1];

  assign w_stage[0] = i_data;

  for (genvar g = 0; g < AW; g++) begin : g_stage
    localparam int S = 1 << g;
    logic [N-1:0] w_rl;
    logic [N-1:0] w_rr;
    assign w_rl = (w_stage[g] << S) | (w_stage[g] >> (N - S));
    assign w_rr = (w_stage[g] >> S) | (w_stage[g] << (N - S));
    assign w_stage[g+1] = !i_amt[g] ? w_stage[g] : (i_left ? w_rl : w_rr);
  end

  assign o_data = w_stage[AW];

endmodule

// File: rtl/xc_funnel_shift_mc.sv
// rtl/xc_funnel_shift_mc.sv - multi-cycle funnel shift / rotate unit (FSR, FSL, ROR, ROL)
//
// Purpose: rotates a 2*XLEN working register by at most STEP bits per cycle and
// returns its upper half, behind a valid/ready request/response handshake.
// Ports:
//   g_clk, g_reset          clock, synchronous active-high reset
//   flush                   abort any in-flight op, back to IDLE next edge
//   req_valid / req_ready   request handshake (ready only in IDLE)
//   req_op                  00 FSR, 01 FSL, 10 ROR, 11 ROL
//   req_rs1, req_rs3        funnel high / low halves (rs3 unused for rotates)
//   req_shamt               shift amount
//   rsp_valid / rsp_ready   response handshake (valid only in DONE)
//   rsp_data                result, held while rsp_ready is low
module xc_funnel_shift_mc
  import xc_fsh_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int STEP = 8,
  localparam int SHW  = $clog2(2 * XLEN)
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs3,
  input  logic [SHW-1:0]  req_shamt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data
);

  localparam int AW = $clog2(STEP) + 1;

  fsh_state_e          r_state;
  fsh_state_e          w_state_nxt;
  logic [2*XLEN-1:0]   r_w;
  logic [SHW-1:0]      r_rem;
  logic                r_left;

  fsh_op_e             w_op;
  logic [SHW-1:0]      w_amt;
  logic [2*XLEN-1:0]   w_load;
  logic [2*XLEN-1:0]   w_rot;
  logic [AW-1:0]       w_step_amt;
  logic                w_accept;
  logic                w_last;

  assign w_op     = fsh_op_e'(req_op);
  assign w_amt    = SHW'(fsh_eff_amt(w_op, FSH_AMT_W'(req_shamt), XLEN));
  // Duplicating rs1 makes the upper half of the funnel a plain rotate of rs1.
  assign w_load   = fsh_is_rot(w_op) ? {req_rs1, req_rs1} : {req_rs1, req_rs3};
  // A flush in the same cycle wins over a new request.
  assign w_accept = (r_state == ST_IDLE) && req_valid && !flush;

  // Per-cycle amount is min(remaining, STEP); the final step lands exactly on 0.
  always_comb begin
    w_step_amt = AW'(STEP);
    if (int'(r_rem) < STEP) begin
      w_step_amt = AW'(r_rem);
    end
  end

  assign w_last = (int'(r_rem) <= STEP);

  xc_fsh_step #(
    .N    (2 * XLEN),
    .STEP (STEP),
    .AW   (AW)
  ) u_step (
    .i_data (r_w),
    .i_amt  (w_step_amt),
    .i_left (r_left),
    .o_data (w_rot)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (w_amt != '0) ? ST_BUSY : ST_DONE;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_w    <= '0;
      r_rem  <= '0;
      r_left <= 1'b0;
    end else if (w_accept) begin
      r_w    <= w_load;
      r_rem  <= w_amt;
      r_left <= fsh_is_left(w_op);
    end else if ((r_state == ST_BUSY) && !flush) begin
      r_w    <= w_rot;
      r_rem  <= r_rem - SHW'(w_step_amt);
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_data  = r_w[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_xc_funnel_shift_mc.sv
// tb/tb_xc_funnel_shift_mc.sv - self-checking bench for xc_funnel_shift_mc
module tb_xc_funnel_shift_mc;

  localparam int XLEN = 32;
  localparam int STEP = 8;
  localparam int SHW  = 6;

  logic            g_clk = 1'b0;
  logic            g_reset = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_op = 2'b00;
  logic [XLEN-1:0] req_rs1 = '0;
  logic [XLEN-1:0] req_rs3 = '0;
  logic [SHW-1:0]  req_shamt = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_data;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  xc_funnel_shift_mc #(.XLEN(XLEN), .STEP(STEP)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs3   (req_rs3),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  always #5 g_clk = ~g_clk;

  // Reference: effective amount, then one-bit rotations of the 64-bit funnel.
  function automatic int ref_amt(input int op, input int sh);
    return (op >= 2) ? (sh % XLEN) : sh;
  endfunction

  function automatic logic [XLEN-1:0] ref_fn(input int op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b, input int sh);
    logic [2*XLEN-1:0] w;
    int amt;
    w   = (op >= 2) ? {a, a} : {a, b};
    amt = ref_amt(op, sh);
    for (int i = 0; i < amt; i++) begin
      if (op == 0 || op == 2) w = {w[0], w[2*XLEN-1:1]};
      else                    w = {w[2*XLEN-2:0], w[2*XLEN-1]};
    end
    return w[2*XLEN-1:XLEN];
  endfunction

  function automatic int ref_lat(input int op, input int sh);
    return (ref_amt(op, sh) + STEP - 1) / STEP;
  endfunction

  // Transaction-level model: 0 idle, 1 computing, 2 result pending.
  int              m_phase = 0;
  int              m_wait  = 0;
  logic [XLEN-1:0] m_data  = '0;

  always @(posedge g_clk) begin
    if (g_reset) begin
      m_phase <= 0;
      m_wait  <= 0;
    end else if (flush) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_data  <= ref_fn(int'(req_op), req_rs1, req_rs3, int'(req_shamt));
          m_wait  <= ref_lat(int'(req_op), int'(req_shamt));
          m_phase <= (ref_lat(int'(req_op), int'(req_shamt)) == 0) ? 2 : 1;
        end
        1: begin
          m_wait <= m_wait - 1;
          if (m_wait == 1) m_phase <= 2;
        end
        default: if (rsp_ready) m_phase <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge g_clk) begin
    if (cmp_en) begin
      chk("model_req_ready", 64'(req_ready), 64'(m_phase == 0));
      chk("model_rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase == 2) chk("model_rsp_data", 64'(rsp_data), 64'(m_data));
    end
  end

  // Issue one op from IDLE, check the literal result and latency (cycles after
  // the accept edge), hold the response for 'hold' extra cycles, then drain it.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int sh, input logic [31:0] exp,
                       input int exp_lat, input int hold);
    int lat;
    logic [31:0] first;
    chk({name, "_ready"}, 64'(req_ready), 64'd1);
    req_op = op; req_rs1 = a; req_rs3 = b; req_shamt = SHW'(sh); req_valid = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(posedge g_clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_data"}, 64'(rsp_data), 64'(exp));
    first = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge g_clk); #1;
      chk({name, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({name, "_hold_data"}, 64'(rsp_data), 64'(first));
      chk({name, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_drain_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_drain_ready"}, 64'(req_ready), 64'd1);
  endtask

  // Start FSL by 63 and kill it in its third BUSY cycle with flush or reset.
  task automatic abort_op(input string name, input bit use_reset);
    req_op = 2'b01; req_rs1 = 32'h12345678; req_rs3 = 32'h9ABCDEF0;
    req_shamt = 6'd63; req_valid = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge g_clk); #1;
    end
    chk({name, "_busy"}, 64'(req_ready), 64'd0);
    if (use_reset) g_reset = 1'b1;
    else           flush = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    flush   = 1'b0;
    chk({name, "_idle_ready"}, 64'(req_ready), 64'd1);
    chk({name, "_idle_valid"}, 64'(rsp_valid), 64'd0);
    if (use_reset) chk({name, "_rst_data"}, 64'(rsp_data), 64'd0);
    repeat (10) begin
      @(posedge g_clk); #1;
      chk({name, "_no_rsp"}, 64'(rsp_valid), 64'd0);
    end
    do_op({name, "_after"}, 2'b00, 32'h12345678, 32'h9ABCDEF0, 8, 32'hF0123456, 2, 0);
  endtask

  initial begin
    // Pin the model against hand-computed values.
    chk("ref_fsr8",   64'(ref_fn(0, 32'h12345678, 32'h9ABCDEF0, 8)),  64'hF0123456);
    chk("ref_fsl36",  64'(ref_fn(1, 32'h12345678, 32'h9ABCDEF0, 36)), 64'hABCDEF01);
    chk("ref_ror33",  64'(ref_fn(2, 32'h80000001, 32'h0, 33)),        64'hC0000000);
    chk("ref_fsl63",  64'(ref_fn(1, 32'h12345678, 32'h9ABCDEF0, 63)), 64'h091A2B3C);
    chk("ref_lat36",  64'(ref_lat(1, 36)), 64'd5);

    repeat (2) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_data",  64'(rsp_data),  64'd0);
    cmp_en = 1'b1;

    do_op("fsr8",  2'b00, 32'h12345678, 32'h9ABCDEF0, 8,  32'hF0123456, 2, 0);
    do_op("fsr0",  2'b00, 32'h12345678, 32'h9ABCDEF0, 0,  32'h12345678, 1, 0);
    do_op("fsl36", 2'b01, 32'h12345678, 32'h9ABCDEF0, 36, 32'hABCDEF01, 6, 0);
    do_op("ror33", 2'b10, 32'h80000001, 32'hFFFFFFFF, 33, 32'hC0000000, 2, 0);
    do_op("rol1",  2'b11, 32'h80000001, 32'hFFFFFFFF, 1,  32'h00000003, 2, 0);
    do_op("fsl63", 2'b01, 32'h12345678, 32'h9ABCDEF0, 63, 32'h091A2B3C, 9, 0);
    do_op("fsr1",  2'b00, 32'h12345678, 32'h9ABCDEF0, 1,  32'h091A2B3C, 2, 0);
    do_op("bp",    2'b00, 32'h12345678, 32'h9ABCDEF0, 8,  32'hF0123456, 2, 2);

    // A request coinciding with flush must be dropped.
    req_op = 2'b00; req_shamt = 6'd0; req_valid = 1'b1; flush = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_req_ready", 64'(req_ready), 64'd1);
    chk("flush_req_valid", 64'(rsp_valid), 64'd0);

    abort_op("flush", 1'b0);
    abort_op("reset", 1'b1);

    repeat (2) @(posedge g_clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
